// File: rtl/branch_pred_unit_pkg.sv
// ============================================================================
// Module      : branch_pred_unit_pkg
// Description : Shared RV32 control-flow encodings and counter states for the
//               branch prediction unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_pred_unit_pkg;

  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;

  localparam logic [2:0] c_f3_beq  = 3'b000;
  localparam logic [2:0] c_f3_bne  = 3'b001;
  localparam logic [2:0] c_f3_blt  = 3'b100;
  localparam logic [2:0] c_f3_bge  = 3'b101;
  localparam logic [2:0] c_f3_bltu = 3'b110;
  localparam logic [2:0] c_f3_bgeu = 3'b111;

  // Two-bit counter states; wider counters are derived from NB_CNT in the top.
  localparam logic [1:0] c_cnt_strong_nt = 2'd0;
  localparam logic [1:0] c_cnt_weak_nt   = 2'd1;
  localparam logic [1:0] c_cnt_weak_t    = 2'd2;
  localparam logic [1:0] c_cnt_strong_t  = 2'd3;

  typedef enum logic [1:0] {
    CF_NONE   = 2'd0,
    CF_BRANCH = 2'd1,
    CF_JUMP   = 2'd2
  } cf_kind_t;

endpackage : branch_pred_unit_pkg

`default_nettype wire

// File: rtl/branch_resolve.sv
// ============================================================================
// Module      : branch_resolve
// Description : Combinational outcome evaluation of a resolving instruction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve
  import branch_pred_unit_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_func3,
  input  logic       i_alu_zero,
  input  logic       i_alu_result,
  output logic       o_actual_taken,
  output cf_kind_t   o_kind
);

  always_comb begin
    o_actual_taken = 1'b0;
    o_kind         = CF_NONE;
    case (i_opcode)
      c_opc_branch: begin
        o_kind = CF_BRANCH;
        case (i_func3)
          c_f3_beq:  o_actual_taken = i_alu_zero;
          c_f3_bne:  o_actual_taken = ~i_alu_zero;
          c_f3_blt:  o_actual_taken = i_alu_result;
          c_f3_bge:  o_actual_taken = ~i_alu_result;
          c_f3_bltu: o_actual_taken = i_alu_result;
          c_f3_bgeu: o_actual_taken = ~i_alu_result;
          default:   o_actual_taken = 1'b0;
        endcase
      end
      c_opc_jal, c_opc_jalr: begin
        o_kind         = CF_JUMP;
        o_actual_taken = 1'b1;
      end
      default: begin
        o_kind         = CF_NONE;
        o_actual_taken = 1'b0;
      end
    endcase
  end

endmodule : branch_resolve

`default_nettype wire

// File: rtl/branch_pred_unit.sv
// ============================================================================
// Module      : branch_pred_unit
// Description : Direct-mapped BTB with saturating counters, EX-stage
//               mispredict detection and redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_pred_unit
  import branch_pred_unit_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int NB_INDEX = 6,
  parameter int NB_CNT   = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_fetch_pc,
  output logic               o_pred_taken,
  output logic [NB_DATA-1:0] o_pred_target,
  input  logic               i_upd_valid,
  input  logic [NB_DATA-1:0] i_upd_pc,
  input  logic [6:0]         i_upd_opcode,
  input  logic [2:0]         i_upd_func3,
  input  logic               i_alu_zero,
  input  logic               i_alu_result,
  input  logic [NB_DATA-1:0] i_upd_target,
  input  logic               i_upd_pred_taken,
  input  logic [NB_DATA-1:0] i_upd_pred_target,
  output logic               o_flush,
  output logic [NB_DATA-1:0] o_redirect_pc,
  output logic [NB_DATA-1:0] o_mispred_cnt
);

  localparam int c_depth  = 1 << NB_INDEX;
  localparam int c_nb_tag = NB_DATA - NB_INDEX - 2;

  localparam logic [NB_CNT-1:0] c_cnt_max     = {NB_CNT{1'b1}};
  localparam logic [NB_CNT-1:0] c_cnt_min     = {NB_CNT{1'b0}};
  localparam logic [NB_CNT-1:0] c_cnt_weak_tk = {1'b1, {(NB_CNT-1){1'b0}}};
  localparam logic [NB_CNT-1:0] c_cnt_weak_nt = {1'b0, {(NB_CNT-1){1'b1}}};

  logic                r_valid   [c_depth];
  logic [c_nb_tag-1:0] r_tag     [c_depth];
  logic [NB_DATA-1:0]  r_target  [c_depth];
  logic                r_is_jump [c_depth];
  logic [NB_CNT-1:0]   r_cnt     [c_depth];
  logic [NB_DATA-1:0]  r_mispred_cnt;

  logic [NB_INDEX-1:0] w_f_idx;
  logic [c_nb_tag-1:0] w_f_tag;
  logic                w_f_hit;
  logic [NB_INDEX-1:0] w_u_idx;
  logic [c_nb_tag-1:0] w_u_tag;
  logic                w_u_hit;
  logic                w_actual_taken;
  cf_kind_t            w_kind;
  logic                w_mispred;
  logic [NB_CNT-1:0]   w_cnt_next;
  logic                w_unused_pc_bits;

  assign w_unused_pc_bits = ^{i_fetch_pc[1:0], i_upd_pc[1:0]};

  // ---------------------------------------------------------------- predict
  assign w_f_idx = i_fetch_pc[NB_INDEX+1:2];
  assign w_f_tag = i_fetch_pc[NB_DATA-1:NB_INDEX+2];
  assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

  // Gated by reset so the outputs are quiet even before the async clear lands.
  assign o_pred_taken  = ~i_rst & w_f_hit &
                         (r_is_jump[w_f_idx] | r_cnt[w_f_idx][NB_CNT-1]);
  assign o_pred_target = o_pred_taken ? r_target[w_f_idx] : '0;

  // ---------------------------------------------------------------- resolve
  branch_resolve u_resolve (
    .i_opcode       (i_upd_opcode),
    .i_func3        (i_upd_func3),
    .i_alu_zero     (i_alu_zero),
    .i_alu_result   (i_alu_result),
    .o_actual_taken (w_actual_taken),
    .o_kind         (w_kind)
  );

  assign w_u_idx = i_upd_pc[NB_INDEX+1:2];
  assign w_u_tag = i_upd_pc[NB_DATA-1:NB_INDEX+2];
  assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

  assign w_mispred = (w_actual_taken != i_upd_pred_taken) ||
                     (w_actual_taken && (i_upd_target != i_upd_pred_target));

  assign o_flush       = i_upd_valid & w_mispred;
  assign o_redirect_pc = !o_flush       ? '0 :
                         w_actual_taken ? i_upd_target :
                                          i_upd_pc + NB_DATA'(4);
  assign o_mispred_cnt = r_mispred_cnt;

  always_comb begin
    w_cnt_next = r_cnt[w_u_idx];
    if (w_actual_taken && (r_cnt[w_u_idx] != c_cnt_max)) begin
      w_cnt_next = r_cnt[w_u_idx] + NB_CNT'(1);
    end else if (!w_actual_taken && (r_cnt[w_u_idx] != c_cnt_min)) begin
      w_cnt_next = r_cnt[w_u_idx] - NB_CNT'(1);
    end
  end

  // ----------------------------------------------------------------- update
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < c_depth; i++) begin
        r_valid[i]   <= 1'b0;
        r_tag[i]     <= '0;
        r_target[i]  <= '0;
        r_is_jump[i] <= 1'b0;
        r_cnt[i]     <= c_cnt_weak_nt;
      end
      r_mispred_cnt <= '0;
    end else begin
      if (o_flush && (r_mispred_cnt != {NB_DATA{1'b1}})) begin
        r_mispred_cnt <= r_mispred_cnt + NB_DATA'(1);
      end
      if (i_upd_valid) begin
        if (w_kind == CF_JUMP) begin
          // Jumps claim the slot unconditionally; the counter is left alone.
          r_valid[w_u_idx]   <= 1'b1;
          r_tag[w_u_idx]     <= w_u_tag;
          r_target[w_u_idx]  <= i_upd_target;
          r_is_jump[w_u_idx] <= 1'b1;
        end else if (w_kind == CF_BRANCH) begin
          if (w_u_hit) begin
            r_cnt[w_u_idx] <= w_cnt_next;
            if (w_actual_taken) begin
              r_target[w_u_idx] <= i_upd_target;
            end
          end else if (w_actual_taken) begin
            r_valid[w_u_idx]   <= 1'b1;
            r_tag[w_u_idx]     <= w_u_tag;
            r_target[w_u_idx]  <= i_upd_target;
            r_is_jump[w_u_idx] <= 1'b0;
            r_cnt[w_u_idx]     <= c_cnt_weak_tk;
          end
        end
      end
    end
  end

endmodule : branch_pred_unit

`default_nettype wire

// File: doc/branch_pred_unit.md
BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

Interface
REQ-001 Parameter NB_DATA, default 32, sets PC/target width.
REQ-002 Parameter NB_INDEX, default 6, sets the table depth to 2**NB_INDEX entries.
REQ-003 Parameter NB_CNT, default 2, sets the saturating-counter width (at least 2).
REQ-004 Port i_clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port i_fetch_pc, input, NB_DATA bits: IF-stage PC to predict.
REQ-007 Port o_pred_taken, output, 1 bit: prediction for i_fetch_pc is taken.
REQ-008 Port o_pred_target, output, NB_DATA bits: predicted target; 0 when o_pred_taken=0.
REQ-009 Port i_upd_valid, input, 1 bit: EX-stage resolution is valid this cycle.
REQ-010 Ports i_upd_pc (NB_DATA), i_upd_opcode (7), i_upd_func3 (3), inputs: resolving instruction.
REQ-011 Ports i_alu_zero (1) and i_alu_result (1), inputs: ALU zero flag and result bit 0.
REQ-012 Port i_upd_target, input, NB_DATA bits: computed target (PC+imm, or rs1+imm for JALR).
REQ-013 Ports i_upd_pred_taken (1) and i_upd_pred_target (NB_DATA), inputs: prediction carried down the pipe.
REQ-014 Ports o_flush (1) and o_redirect_pc (NB_DATA), outputs: mispredict flush and corrected fetch PC.
REQ-015 Port o_mispred_cnt, output, NB_DATA bits: saturating count of mispredictions.

Function
REQ-016 Index = pc[NB_INDEX+1:2]; tag = pc[NB_DATA-1:NB_INDEX+2].
REQ-017 Each entry: valid, tag, target, is_jump, NB_CNT-bit counter.
REQ-018 Prediction is combinational from registered table state.
- Hit: valid and tag match.
- o_pred_taken = hit and (is_jump or counter MSB=1).
REQ-019 Actual outcome is evaluated only when i_upd_valid=1:
- Branch opcode 1100011 uses func3: BEQ zero; BNE !zero; BLT/BLTU result; BGE/BGEU !result.
- Undefined branch func3 resolves not taken.
- JAL 1101111 and JALR 1100111 are always taken.
- Any other opcode is non-control-flow and resolves not taken with no table write.
REQ-020 Mispredict = actual_taken != i_upd_pred_taken, or (actual_taken and i_upd_target != i_upd_pred_target).
REQ-021 o_flush equals mispredict gated by i_upd_valid, in the same cycle (zero latency).
- o_redirect_pc = actual_taken ? i_upd_target : i_upd_pc+4 (mod 2**NB_DATA).
- o_redirect_pc = 0 when o_flush=0.
REQ-022 Branch update at the next edge:
- On hit, the counter increments if taken, decrements if not, saturating at 0 and 2**NB_CNT-1.
- On miss and taken, the entry is allocated: valid=1, tag, target, is_jump=0, counter=weakly-taken (2**(NB_CNT-1)).
- On miss and not taken, there is no write.
REQ-023 Jump update: the entry is written valid=1, tag, target=i_upd_target, is_jump=1, counter unchanged; this overwrites any alias.
REQ-024 A hit entry always has its target rewritten with i_upd_target when actual_taken=1.
REQ-025 Same-cycle update and predict to the same index: the prediction uses the pre-update entry; the new value is visible the next cycle.
REQ-026 o_mispred_cnt increments by 1 on each cycle where o_flush=1 and holds at 2**NB_DATA-1.

Reset
REQ-027 While i_rst=1, regardless of the clock:
- All valid bits = 0.
- Counters = weakly-not-taken (2**(NB_CNT-1)-1).
- Targets and tags = 0.
- o_mispred_cnt = 0.
REQ-028 During reset, outputs are o_pred_taken=0 and o_pred_target=0; o_flush and o_redirect_pc follow REQ-021 combinationally.
REQ-029 An update coinciding with reset assertion is discarded; reset mid-training loses all history.

Structure
REQ-030 A shared package holds:
- Opcode constants for BRANCH, JAL and JALR.
- Func3 constants for BEQ, BNE, BLT, BGE, BLTU and BGEU.
- Counter-state constants.
REQ-031 Outcome evaluation (REQ-019) is a single combinational sub-module, branch_resolve; the table and counters reside in branch_pred_unit.

Verification
REQ-032 After reset, fetch 0x100 gives pred_taken=0; then upd BEQ pc=0x100, zero=1, target=0x140, pred_taken=0 gives flush=1, redirect=0x140, cnt=1; the next fetch 0x100 gives pred_taken=1, target=0x140.
REQ-033 Train BNE pc=0x200 taken three times (counter saturates at 3), then resolve not-taken with pred_taken=1 and target 0x240: flush=1, redirect=0x204; the next prediction is still taken (counter=2).
REQ-034 JALR pc=0x300 predicted target 0x400, actual i_upd_target=0x480: flush=1, redirect=0x480; the next fetch 0x300 predicts 0x480.
REQ-035 Aliasing: allocate pc=0x100, then JAL pc=0x200 (index 0 with NB_INDEX=6); fetch 0x100 then misses (pred_taken=0).
REQ-036 Same-cycle fetch and update to index 5: the old prediction is returned that cycle and the new one the next cycle; i_rst asserted mid-run clears all state asynchronously, before the next edge.
